// File: rtl/rca_share_sched.sv
// Two-port round-robin add scheduler that time-shares one 4-bit ripple-carry slice.
// Operands are processed LS nibble first over WIDTH/4 cycles with a registered carry.
module rca_share_sched #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_t;

    state_t           state_q;
    logic             ptr_q;
    logic             id_q;
    logic [KW-1:0]    k_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    logic [1:0] vld;
    logic       grant;
    logic       idle;
    logic       accept;
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_s;
    logic       slice_co;
    logic       carry;

    // Pointer requester wins if it asks, otherwise the other one.
    assign vld    = {req1_valid, req0_valid};
    assign grant  = vld[ptr_q] ? ptr_q : ~ptr_q;
    // Gated by rst_n so the readies read as 0 while reset is held.
    assign idle   = rst_n && (state_q == StIdle);
    assign req0_ready = idle && req0_valid && (grant == 1'b0);
    assign req1_ready = idle && req1_valid && (grant == 1'b1);
    assign accept = req0_ready || req1_ready;

    assign slice_a = a_q[{k_q, 2'b00} +: 4];
    assign slice_b = b_q[{k_q, 2'b00} +: 4];

    // The one shared slice: four full-adder cells in a ripple chain.
    always_comb begin
        carry   = c_q;
        slice_s = '0;
        for (int i = 0; i < 4; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ carry;
            carry      = (slice_a[i] & slice_b[i]) | (carry & (slice_a[i] ^ slice_b[i]));
        end
        slice_co = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= grant ? req1_a : req0_a;
                        b_q     <= grant ? req1_b : req0_b;
                        c_q     <= grant ? req1_cin : req0_cin;
                        id_q    <= grant;
                        k_q     <= '0;
                        ptr_q   <= ~grant;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q[{k_q, 2'b00} +: 4] <= slice_s;
                    c_q <= slice_co;
                    k_q <= k_q + 1'b1;
                    if (k_q == KLAST) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = c_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rca_share_sched.sv
// Directed bench for rca_share_sched: vector table plus hand-written
// backpressure, mid-operation reset, contention and WIDTH=8 sequences.
module tb_rca_share_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic        rsp_valid, rsp_id, rsp_cout, busy;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_sum;

    logic        w8_req0_valid = 1'b0, w8_req1_valid = 1'b0;
    logic        w8_req0_ready, w8_req1_ready;
    logic [7:0]  w8_req0_a = '0, w8_req0_b = '0, w8_req1_a = '0, w8_req1_b = '0;
    logic        w8_req0_cin = 1'b0, w8_req1_cin = 1'b0;
    logic        w8_rsp_valid, w8_rsp_id, w8_rsp_cout, w8_busy;
    logic        w8_rsp_ready = 1'b0;
    logic [7:0]  w8_rsp_sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_share_sched #(.WIDTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    rca_share_sched #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (w8_req0_valid),
        .req0_ready (w8_req0_ready),
        .req0_a     (w8_req0_a),
        .req0_b     (w8_req0_b),
        .req0_cin   (w8_req0_cin),
        .req1_valid (w8_req1_valid),
        .req1_ready (w8_req1_ready),
        .req1_a     (w8_req1_a),
        .req1_b     (w8_req1_b),
        .req1_cin   (w8_req1_cin),
        .rsp_valid  (w8_rsp_valid),
        .rsp_ready  (w8_rsp_ready),
        .rsp_id     (w8_rsp_id),
        .rsp_sum    (w8_rsp_sum),
        .rsp_cout   (w8_rsp_cout),
        .busy       (w8_busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_sum"}, rsp_sum, 0);
        check({tag, "_rsp_cout"}, rsp_cout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_single(input vec_t v);
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
        end
        #1;
        check("ready_own", v.id ? req1_ready : req0_ready, 1);
        check("ready_other", v.id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("busy_in_add", busy, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 4);
        check("rsp_sum", rsp_sum, v.exp_sum);
        check("rsp_cout", rsp_cout, v.exp_cout);
        check("rsp_id", rsp_id, v.id);
        @(posedge clk); #1;
        check("rsp_valid_drop", rsp_valid, 0);
        check("busy_drop", busy, 0);
    endtask

    task automatic do_w8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        @(negedge clk);
        w8_rsp_ready = 1'b1;
        w8_req0_valid = 1'b1; w8_req0_a = a; w8_req0_b = b; w8_req0_cin = cin;
        #1;
        check("w8_ready", w8_req0_ready, 1);
        @(posedge clk); #1;
        w8_req0_valid = 1'b0;
        n = 0;
        while (!w8_rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", n, 2);
        check("w8_rsp_sum", w8_rsp_sum, exp_sum);
        check("w8_rsp_cout", w8_rsp_cout, exp_cout);
        check("w8_rsp_id", w8_rsp_id, 0);
        @(posedge clk); #1;
        check("w8_busy_drop", w8_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        int last_cyc;
        logic exp_id;

        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        // Reset with both requesters asking: everything must read 0.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        check_all_zero("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_single(vecs[i]);
        end

        // Backpressure: hold DONE for 10 cycles while both requesters ask.
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F01; req0_cin = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_sum", rsp_sum, 16'h1000);
            check("hold_rsp_cout", rsp_cout, 0);
            check("hold_rsp_id", rsp_id, 0);
            check("hold_busy", busy, 1);
            check("hold_req0_ready", req0_ready, 0);
            check("hold_req1_ready", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_busy", busy, 0);
        check("release_rsp_valid", rsp_valid, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset in the 2nd ADD cycle of a req0 operation (leaves ptr at 1 otherwise).
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'hF00F; req1_b = 16'h1FF1; req1_cin = 1'b1;
        #1;
        check_all_zero("midadd_reset");
        @(negedge clk);
        check("reset_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        check("post_reset_req0_ready", req0_ready, 1);
        check("post_reset_req1_ready", req1_ready, 0);

        // Continuous contention: grants alternate and are exactly 6 cycles apart.
        last_cyc = 0;
        for (int op = 0; op < 4; op++) begin
            exp_id = op[0];
            n = 0;
            while (!(req0_ready || req1_ready) && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("contend_grant_seen", (req0_ready || req1_ready), 1);
            check("contend_grant_id", req1_ready, exp_id);
            check("contend_one_ready", req0_ready && req1_ready, 0);
            if (op > 0) begin
                check("contend_spacing", cyc - last_cyc, 6);
            end
            last_cyc = cyc;
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("contend_rsp_id", rsp_id, exp_id);
            check("contend_rsp_sum", rsp_sum, exp_id ? 16'h1001 : 16'h3333);
            check("contend_rsp_cout", rsp_cout, exp_id ? 1 : 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("contend_end_busy", busy, 0);

        // Narrow build: two-slice operation.
        do_w8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
        do_w8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        do_w8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
